// File: rtl/prt_scaler_pkg.sv
// Shared types and select-clamping helper for the scaler kernel tap selector.
// Latency: combinational helpers only.
// Backpressure: not applicable.
package prt_scaler_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_EDGE   = 2'd1,
        MODE_BYPASS = 2'd2
    } mode_t;

    // Effective select for one lane; fields are wide enough for any legal geometry.
    typedef struct packed {
        logic [7:0] line;
        logic [7:0] tap;
        logic       err;
    } sel_res_t;

    // Bypass wins outright; otherwise an out-of-range select collapses to (0,0)
    // and flags an error, and edge mode pulls the tap towards the newest pixel
    // until enough pixels of the line have arrived.
    function automatic sel_res_t sel_clamp(
        input int unsigned line,
        input int unsigned tap,
        input int unsigned ecnt,
        input logic [1:0]  mode,
        input int unsigned n_lines,
        input int unsigned n_taps,
        input int unsigned ctr
    );
        sel_res_t r;
        r = '0;
        if (mode == MODE_BYPASS) begin
            r.tap = 8'(ctr);
        end else if (line >= n_lines || tap >= n_taps) begin
            r.err = 1'b1;
        end else begin
            r.line = 8'(line);
            r.tap  = 8'(tap);
            if (mode == MODE_EDGE && tap < (n_taps - 1 - ecnt))
                r.tap = 8'(n_taps - 1 - ecnt);
        end
        return r;
    endfunction

endpackage

// File: rtl/prt_scaler_krnl_sel_lane.sv
// One output lane: muxes the registered window down to a single tap.
// Latency: 1 clock from win_vld to out_dat update.
// Backpressure: none; out_dat holds while win_vld is low.
module prt_scaler_krnl_sel_lane #(
    parameter int P_BPC   = 8,
    parameter int P_LINES = 2,
    parameter int P_TAPS  = 5,
    parameter int LW      = 1,
    parameter int TW      = 3
) (
    input  logic                              core_clk,
    input  logic                              arst_n,
    input  logic                              win_vld,
    input  logic [P_LINES*P_TAPS*P_BPC-1:0]   win_dat,
    input  logic [LW+TW-1:0]                  sel,
    output logic [P_BPC-1:0]                  out_dat
);

    logic [P_BPC-1:0] mux_dat;

    // Select is already clamped upstream, so exactly one element matches.
    always_comb begin
        mux_dat = '0;
        for (int l = 0; l < P_LINES; l++) begin
            for (int t = 0; t < P_TAPS; t++) begin
                if (sel == {LW'(l), TW'(t)})
                    mux_dat = win_dat[(l*P_TAPS+t)*P_BPC +: P_BPC];
            end
        end
    end

    // Output register loads only on a valid stage-1 beat.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n)
            out_dat <= '0;
        else if (win_vld)
            out_dat <= mux_dat;
    end

endmodule

// File: rtl/prt_scaler_krnl_sel.sv
// Kernel tap selector: routes P_OUTS selected window taps to the multiplier lanes.
// Latency: 2 clocks DE_IN to DE_OUT; ERR_OUT 1 clock after an errored beat.
// Backpressure: none; every input beat is accepted.
module prt_scaler_krnl_sel
    import prt_scaler_pkg::*;
#(
    parameter int P_BPC   = 8,
    parameter int P_LINES = 2,
    parameter int P_TAPS  = 5,
    parameter int P_OUTS  = 1
) (
    input  logic                            CLK_IN,
    input  logic                            RST_IN,
    input  logic [1:0]                      MODE_IN,
    input  logic                            DE_IN,
    input  logic                            SOL_IN,
    input  logic [P_LINES*P_TAPS*P_BPC-1:0] DAT_IN,
    input  logic [P_OUTS*($clog2((P_LINES > 2) ? P_LINES : 2)
                 + $clog2((P_TAPS > 2) ? P_TAPS : 2))-1:0] SEL_IN,
    input  logic                            ERR_CLR_IN,
    output logic [P_OUTS*P_BPC-1:0]         DAT_OUT,
    output logic                            DE_OUT,
    output logic                            ERR_OUT
);

    localparam int LW  = $clog2((P_LINES > 2) ? P_LINES : 2);
    localparam int TW  = $clog2((P_TAPS > 2) ? P_TAPS : 2);
    localparam int SW  = LW + TW;
    localparam int CTR = (P_TAPS - 1) / 2;
    localparam logic [TW-1:0] EMAX   = TW'(P_TAPS - 1);
    localparam logic [TW-1:0] ESTART = (P_TAPS > 1) ? TW'(1) : TW'(0);

    logic [TW-1:0]                  ecnt, ecnt_use, ecnt_nxt;
    logic [P_OUTS*SW-1:0]           esel_d, esel_q;
    logic                           err_evt;
    logic                           vld1;
    logic [P_LINES*P_TAPS*P_BPC-1:0] win_q;
    sel_res_t                       res;

    // Per-lane effective select; MODE_IN is folded in here, so the registered
    // select carries the beat's mode forward without a separate mode register.
    always_comb begin
        ecnt_use = SOL_IN ? '0 : ecnt;
        ecnt_nxt = SOL_IN ? ESTART : ((ecnt == EMAX) ? ecnt : ecnt + 1'b1);
        esel_d   = '0;
        err_evt  = 1'b0;
        res      = '0;
        for (int k = 0; k < P_OUTS; k++) begin
            res = sel_clamp(32'(SEL_IN[k*SW+TW +: LW]), 32'(SEL_IN[k*SW +: TW]),
                            32'(ecnt_use), MODE_IN, P_LINES, P_TAPS, CTR);
            esel_d[k*SW +: SW] = {LW'(res.line), TW'(res.tap)};
            err_evt = err_evt | res.err;
        end
    end

    // Stage 1: capture window, select and edge count on valid input beats.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            vld1   <= 1'b0;
            ecnt   <= '0;
            win_q  <= '0;
            esel_q <= '0;
        end else begin
            vld1 <= DE_IN;
            if (DE_IN) begin
                ecnt   <= ecnt_nxt;
                win_q  <= DAT_IN;
                esel_q <= esel_d;
            end
        end
    end

    // Stage 2 valid tracks stage 1 unconditionally.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN)
            DE_OUT <= 1'b0;
        else
            DE_OUT <= vld1;
    end

    // Sticky error: a new error event beats a simultaneous clear.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN)
            ERR_OUT <= 1'b0;
        else if (DE_IN && err_evt)
            ERR_OUT <= 1'b1;
        else if (ERR_CLR_IN)
            ERR_OUT <= 1'b0;
    end

    for (genvar k = 0; k < P_OUTS; k++) begin : g_lane
        prt_scaler_krnl_sel_lane #(
            .P_BPC   (P_BPC),
            .P_LINES (P_LINES),
            .P_TAPS  (P_TAPS),
            .LW      (LW),
            .TW      (TW)
        ) u_lane (
            .core_clk (CLK_IN),
            .arst_n   (RST_IN),
            .win_vld  (vld1),
            .win_dat  (win_q),
            .sel      (esel_q[k*SW +: SW]),
            .out_dat  (DAT_OUT[k*P_BPC +: P_BPC])
        );
    end

endmodule

// File: tb/tb_prt_scaler_krnl_sel.sv
module tb_prt_scaler_krnl_sel;

    localparam int BPC = 8;
    localparam int NL  = 2;
    localparam int NT  = 5;
    localparam int NO  = 2;
    localparam int SW  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [1:0]            mode = '0;
    logic                  de = 1'b0;
    logic                  sol = 1'b0;
    logic                  clr = 1'b0;
    logic [NL*NT*BPC-1:0]  dat = '0;
    logic [NO*SW-1:0]      sel = '0;
    logic [NO*BPC-1:0]     dout;
    logic                  dout_de;
    logic                  err;

    always #5 clk = ~clk;

    prt_scaler_krnl_sel #(
        .P_BPC (BPC), .P_LINES (NL), .P_TAPS (NT), .P_OUTS (NO)
    ) dut (
        .CLK_IN     (clk),
        .RST_IN     (rst_n),
        .MODE_IN    (mode),
        .DE_IN      (de),
        .SOL_IN     (sol),
        .DAT_IN     (dat),
        .SEL_IN     (sel),
        .ERR_CLR_IN (clr),
        .DAT_OUT    (dout),
        .DE_OUT     (dout_de),
        .ERR_OUT    (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: window contents, pixels-seen count, pending beats.
    int                win [NL][NT];
    int                pos;
    bit                m_err;
    bit                d1_de, d2_de;
    logic [NO*BPC-1:0] d1_dat, d2_dat, exp_dat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pos = 0; m_err = 0; d1_de = 0; d2_de = 0;
        d1_dat = '0; d2_dat = '0; exp_dat = '0;
    endtask

    task automatic set_ramp();
        for (int l = 0; l < NL; l++)
            for (int t = 0; t < NT; t++)
                win[l][t] = 16*l + t;
    endtask

    task automatic set_rand();
        for (int l = 0; l < NL; l++)
            for (int t = 0; t < NT; t++)
                win[l][t] = $urandom_range(0, 255);
    endtask

    // One clock: drive a beat, predict it, then check outputs after the edge.
    task automatic step(input bit de_i, input bit sol_i, input logic [1:0] mode_i,
                        input logic [7:0] sel_i, input bit clr_i, input string tag);
        logic [NO*BPC-1:0] cur;
        bit   cur_err;
        int   p, line, tap, s, v;
        de = de_i; sol = sol_i; mode = mode_i; sel = sel_i; clr = clr_i;
        for (int l = 0; l < NL; l++)
            for (int t = 0; t < NT; t++)
                dat[(l*NT+t)*BPC +: BPC] = 8'(win[l][t]);
        cur = '0; cur_err = 0;
        p = sol_i ? 0 : pos;
        for (int k = 0; k < NO; k++) begin
            s = int'(sel_i[k*SW +: SW]);
            line = s / 8; tap = s % 8;
            if (mode_i == 2'd2) begin
                v = win[0][(NT-1)/2];
            end else if (line >= NL || tap >= NT) begin
                v = win[0][0]; cur_err = 1;
            end else begin
                if (mode_i == 2'd1 && tap < NT-1-p) tap = NT-1-p;
                v = win[line][tap];
            end
            cur[k*BPC +: BPC] = 8'(v);
        end
        @(posedge clk); #1;
        if (de_i) pos = sol_i ? 1 : ((pos < NT-1) ? pos + 1 : NT-1);
        if (de_i && cur_err) m_err = 1;
        else if (clr_i)      m_err = 0;
        d2_de = d1_de; d2_dat = d1_dat;
        d1_de = de_i;  d1_dat = cur;
        if (d2_de) exp_dat = d2_dat;
        check({tag, ".de"},  32'(dout_de), 32'(d2_de));
        check({tag, ".dat"}, 32'(dout),    32'(exp_dat));
        check({tag, ".err"}, 32'(err),     32'(m_err));
    endtask

    initial begin
        model_reset();
        set_ramp();
        repeat (2) @(posedge clk);
        #1;
        check("rst.dat", 32'(dout), 32'h0);
        check("rst.de",  32'(dout_de), 32'h0);
        check("rst.err", 32'(err), 32'h0);
        rst_n = 1'b1;

        // Mode 0 sweep of every select code on both lanes.
        for (int i = 0; i < 16; i++)
            step(1, i == 0, 2'd0, {4'(i), 4'(i)}, 0, "sweep");
        step(0, 0, 2'd0, 8'h00, 0, "sweep_tail");
        step(0, 0, 2'd0, 8'h00, 1, "sweep_clr");
        check("sweep.last", 32'(dout), 32'h0000);

        // Edge replicate ramp-in with a 1,0,0,1 DE gap in the middle.
        step(1, 1, 2'd1, 8'h00, 0, "edge");
        step(1, 0, 2'd1, 8'h00, 0, "edge");
        step(0, 0, 2'd1, 8'h00, 0, "gap");
        step(0, 0, 2'd1, 8'h00, 0, "gap");
        step(1, 0, 2'd1, 8'h00, 0, "edge");
        for (int i = 0; i < 3; i++)
            step(1, 0, 2'd1, 8'h00, 0, "edge");
        step(0, 0, 2'd1, 8'h00, 0, "edge_tail");
        step(0, 0, 2'd1, 8'h00, 0, "edge_tail");

        // Bypass ignores an out-of-range select.
        set_rand();
        for (int i = 0; i < 3; i++)
            step(1, 0, 2'd2, 8'hFF, 0, "bypass");
        step(0, 0, 2'd2, 8'hFF, 0, "bypass_tail");
        check("bypass.lanes", 32'(dout), 32'({8'(win[0][2]), 8'(win[0][2])}));

        // Set beats a simultaneous clear; a later clear alone drops the flag.
        step(1, 0, 2'd0, 8'h0D, 1, "errclr");
        step(0, 0, 2'd0, 8'h00, 1, "clr");
        step(0, 0, 2'd0, 8'h00, 0, "idle");

        // Random traffic, including reserved mode 3.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) set_rand();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                 2'($urandom), 8'($urandom), $urandom_range(0, 3) == 0, "rand");
        end

        // Mid-stream asynchronous reset while output is valid.
        set_ramp();
        step(1, 0, 2'd0, 8'h9D, 0, "pre_rst");
        step(1, 0, 2'd0, 8'h12, 0, "pre_rst");
        step(1, 0, 2'd0, 8'h03, 0, "pre_rst");
        check("pre_rst.de", 32'(dout_de), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.dat", 32'(dout), 32'h0);
        check("arst.de",  32'(dout_de), 32'h0);
        check("arst.err", 32'(err), 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1, 0, 2'd1, 8'h00, 0, "post_rst");
        step(0, 0, 2'd1, 8'h00, 0, "post_rst");
        step(0, 0, 2'd1, 8'h00, 0, "post_rst");
        check("post_rst.edge", 32'(dout), 32'h0404);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
